// File: rtl/rv_mem_stage_pkg.sv
// Shared encodings for the RV32I MEM stage: load/store width codes,
// writeback source select codes and access FSM states.
package rv_mem_stage_pkg;

  typedef enum logic [2:0] {
    BC_B  = 3'b000,
    BC_H  = 3'b001,
    BC_W  = 3'b010,
    BC_BU = 3'b100,
    BC_HU = 3'b101
  } bytectrl_e;

  // Access size lives in bytectrl[1:0]; bytectrl[2] selects zero-extension.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    PS_ALU   = 2'b00,
    PS_IMM   = 2'b01,
    PS_PCIMM = 2'b10,
    PS_PC4   = 2'b11
  } presel_e;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'b00,
    MEM_ST_REQ  = 2'b01,
    MEM_ST_WAIT = 2'b10
  } mem_state_e;

endpackage

// File: rtl/rv_mem_stage_lsu_align.sv
// Combinational load/store lane handling: byte enables, store data
// replication, load byte/half extraction with sign/zero extension.
module rv_mem_stage_lsu_align
  import rv_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_bytectrl,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_misaligned
);

  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic uns);
    return uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic uns);
    return uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
  endfunction

  logic [XLEN-1:0] w_lane;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wd;
    o_ld_data    = i_rdata;
    o_misaligned = 1'b0;
    unique case (i_bytectrl[1:0])
      SZ_B: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wd[7:0]}};
        o_ld_data = ext_byte(w_lane[7:0], i_bytectrl[2]);
      end
      SZ_H: begin
        o_be         = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wd[15:0]}};
        o_ld_data    = ext_half(w_lane[15:0], i_bytectrl[2]);
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_wd;
        o_ld_data    = i_rdata;
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/rv_mem_stage.sv
// RV32I MEM stage: req/gnt/rvalid data-memory access FSM, pipeline stall,
// MEM->EX forward value and MEM/WB writeback registers.
module rv_mem_stage
  import rv_mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DMEM_AW = 32
) (
  input  logic               i_mem_clk,
  input  logic               i_mem_rst,
  input  logic               i_mem_is_load,
  input  logic               i_mem_dmem_we,
  input  logic [2:0]         i_mem_dmem_bytectrl,
  input  logic [XLEN-1:0]    i_mem_alu_res,
  input  logic [XLEN-1:0]    i_mem_immext_res,
  input  logic [XLEN-1:0]    i_mem_pc_plus_imm,
  input  logic [XLEN-1:0]    i_mem_pc_plus_4,
  input  logic [XLEN-1:0]    i_mem_dmem_wd,
  input  logic               i_mem_rf_we,
  input  logic [4:0]         i_mem_rf_wa,
  input  logic [1:0]         i_mem_rf_wd_pre_sel,
  output logic               o_mem_dmem_req,
  output logic               o_mem_dmem_wr,
  output logic [DMEM_AW-1:0] o_mem_dmem_addr,
  output logic [3:0]         o_mem_dmem_be,
  output logic [XLEN-1:0]    o_mem_dmem_wdata,
  input  logic               i_mem_dmem_gnt,
  input  logic               i_mem_dmem_rvalid,
  input  logic [XLEN-1:0]    i_mem_dmem_rdata,
  output logic               o_mem_stall,
  output logic               o_mem_misaligned,
  output logic [XLEN-1:0]    o_mem_ex_rf_rd_mem,
  output logic               o_mem_wb_rf_we,
  output logic [4:0]         o_mem_wb_rf_wa,
  output logic [XLEN-1:0]    o_mem_wb_rf_wd
);

  mem_state_e      r_state;
  logic            w_access;
  logic            w_load;
  logic            w_store;
  logic            w_mis_raw;
  logic            w_req;
  logic            w_misaligned;
  logic            w_stall;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ld_data;
  logic [XLEN-1:0] w_presel_res;

  logic            r_wb_rf_we_p1;
  logic [4:0]      r_wb_rf_wa_p1;
  logic [XLEN-1:0] r_wb_rf_wd_p1;

  rv_mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
    .i_bytectrl   (i_mem_dmem_bytectrl),
    .i_addr_lo    (i_mem_alu_res[1:0]),
    .i_wd         (i_mem_dmem_wd),
    .i_rdata      (i_mem_dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ld_data    (w_ld_data),
    .o_misaligned (w_mis_raw)
  );

  // A load flag takes priority if both load and store are set.
  assign w_load   = i_mem_is_load;
  assign w_store  = i_mem_dmem_we & ~i_mem_is_load;
  assign w_access = i_mem_is_load | i_mem_dmem_we;

  always_comb begin
    w_req = 1'b0;
    if (!i_mem_rst) begin
      unique case (r_state)
        MEM_ST_IDLE: w_req = w_access & ~w_mis_raw;
        MEM_ST_REQ:  w_req = 1'b1;
        default:     w_req = 1'b0;
      endcase
    end
  end

  assign w_misaligned = ~i_mem_rst & (r_state == MEM_ST_IDLE) & w_access & w_mis_raw;

  assign w_stall = ~i_mem_rst &
                   ((w_req & ~i_mem_dmem_gnt) |
                    (w_req & i_mem_dmem_gnt & w_load) |
                    ((r_state == MEM_ST_WAIT) & ~i_mem_dmem_rvalid));

  always_ff @(posedge i_mem_clk) begin
    if (i_mem_rst) begin
      r_state <= MEM_ST_IDLE;
    end else begin
      unique case (r_state)
        MEM_ST_IDLE, MEM_ST_REQ: begin
          if (w_req) begin
            if (!i_mem_dmem_gnt) r_state <= MEM_ST_REQ;
            else if (w_load)     r_state <= MEM_ST_WAIT;
            else                 r_state <= MEM_ST_IDLE;
          end
        end
        MEM_ST_WAIT: begin
          if (i_mem_dmem_rvalid) r_state <= MEM_ST_IDLE;
        end
        default: r_state <= MEM_ST_IDLE;
      endcase
    end
  end

  // Bus side is quiet whenever no request is presented; inputs are held
  // by the stall, so these stay stable for the life of a request.
  assign o_mem_dmem_req   = w_req;
  assign o_mem_dmem_wr    = w_req & w_store;
  assign o_mem_dmem_addr  = w_req ? {i_mem_alu_res[DMEM_AW-1:2], 2'b00} : '0;
  assign o_mem_dmem_be    = w_req ? w_be : 4'b0000;
  assign o_mem_dmem_wdata = (w_req & w_store) ? w_wdata : '0;
  assign o_mem_stall      = w_stall;
  assign o_mem_misaligned = w_misaligned;

  always_comb begin
    w_presel_res = i_mem_alu_res;
    unique case (i_mem_rf_wd_pre_sel)
      PS_ALU:   w_presel_res = i_mem_alu_res;
      PS_IMM:   w_presel_res = i_mem_immext_res;
      PS_PCIMM: w_presel_res = i_mem_pc_plus_imm;
      PS_PC4:   w_presel_res = i_mem_pc_plus_4;
      default:  w_presel_res = i_mem_alu_res;
    endcase
  end

  assign o_mem_ex_rf_rd_mem = w_presel_res;

  // MEM -> WB boundary
  always_ff @(posedge i_mem_clk) begin
    if (i_mem_rst) begin
      r_wb_rf_we_p1 <= 1'b0;
      r_wb_rf_wa_p1 <= '0;
      r_wb_rf_wd_p1 <= '0;
    end else if (w_stall) begin
      r_wb_rf_we_p1 <= 1'b0;
    end else begin
      r_wb_rf_we_p1 <= i_mem_rf_we & ~w_misaligned;
      r_wb_rf_wa_p1 <= i_mem_rf_wa;
      r_wb_rf_wd_p1 <= w_load ? w_ld_data : w_presel_res;
    end
  end

  assign o_mem_wb_rf_we = r_wb_rf_we_p1;
  assign o_mem_wb_rf_wa = r_wb_rf_wa_p1;
  assign o_mem_wb_rf_wd = r_wb_rf_wd_p1;

endmodule

// File: tb/tb_rv_mem_stage.sv
// Directed bench for rv_mem_stage: single-cycle vector table plus
// hand-written multi-cycle load/store, misalign and reset sequences.
module tb_rv_mem_stage;

  localparam logic [31:0] IMM_C   = 32'h12345000;
  localparam logic [31:0] PCIMM_C = 32'h00401234;
  localparam logic [31:0] PC4_C   = 32'h00000104;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load, dmem_we;
  logic [2:0]  bytectrl;
  logic [31:0] alu_res, immext, pcimm, pc4, dmem_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [1:0]  presel;
  logic        req, wr;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        stall, mis;
  logic [31:0] fwd;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_mem_stage #(.XLEN(32), .DMEM_AW(32)) dut (
    .i_mem_clk           (clk),
    .i_mem_rst           (rst),
    .i_mem_is_load       (is_load),
    .i_mem_dmem_we       (dmem_we),
    .i_mem_dmem_bytectrl (bytectrl),
    .i_mem_alu_res       (alu_res),
    .i_mem_immext_res    (immext),
    .i_mem_pc_plus_imm   (pcimm),
    .i_mem_pc_plus_4     (pc4),
    .i_mem_dmem_wd       (dmem_wd),
    .i_mem_rf_we         (rf_we),
    .i_mem_rf_wa         (rf_wa),
    .i_mem_rf_wd_pre_sel (presel),
    .o_mem_dmem_req      (req),
    .o_mem_dmem_wr       (wr),
    .o_mem_dmem_addr     (addr),
    .o_mem_dmem_be       (be),
    .o_mem_dmem_wdata    (wdata),
    .i_mem_dmem_gnt      (gnt),
    .i_mem_dmem_rvalid   (rvalid),
    .i_mem_dmem_rdata    (rdata),
    .o_mem_stall         (stall),
    .o_mem_misaligned    (mis),
    .o_mem_ex_rf_rd_mem  (fwd),
    .o_mem_wb_rf_we      (wb_we),
    .o_mem_wb_rf_wa      (wb_wa),
    .o_mem_wb_rf_wd      (wb_wd)
  );

  typedef struct {
    string       nm;
    logic        ld, we;
    logic [2:0]  bc;
    logic [31:0] a, wd;
    logic [1:0]  ps;
    logic        rfwe;
    logic [4:0]  wa;
    logic        e_req, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_fwd;
    logic        e_wbwe;
    logic [31:0] e_wbwd;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic we, input logic [2:0] bc,
                       input logic [31:0] a, input logic [31:0] wd, input logic [1:0] ps,
                       input logic rfw, input logic [4:0] wa);
    is_load = ld; dmem_we = we; bytectrl = bc; alu_res = a; dmem_wd = wd;
    presel = ps; rf_we = rfw; rf_wa = wa;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input string nm, input logic [2:0] bc, input logic [31:0] a,
                          input logic [31:0] rd, input int gdly, input int rdly,
                          input logic [31:0] exp);
    drive(1'b1, 1'b0, bc, a, 32'h0, 2'b00, 1'b1, 5'd9);
    gnt = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      settle();
      chk({nm, "_req_wait_gnt"}, req, 1'b1);
      chk({nm, "_stall_wait_gnt"}, stall, 1'b1);
      tick();
    end
    gnt = 1'b1;
    settle();
    chk({nm, "_req"}, req, 1'b1);
    chk({nm, "_wr"}, wr, 1'b0);
    chk({nm, "_addr"}, addr, {a[31:2], 2'b00});
    chk({nm, "_stall_gnt"}, stall, 1'b1);
    tick();
    gnt = 1'b0;
    chk({nm, "_bubble"}, wb_we, 1'b0);
    for (int i = 0; i < rdly; i++) begin
      settle();
      chk({nm, "_stall_wait_rv"}, stall, 1'b1);
      chk({nm, "_req_in_wait"}, req, 1'b0);
      tick();
    end
    rdata = rd; rvalid = 1'b1;
    settle();
    chk({nm, "_stall_rv"}, stall, 1'b0);
    tick();
    rvalid = 1'b0;
    drive_idle();
    chk({nm, "_wb_we"}, wb_we, 1'b1);
    chk({nm, "_wb_wa"}, wb_wa, 5'd9);
    chk({nm, "_wb_wd"}, wb_wd, exp);
  endtask

  initial begin
    immext = IMM_C; pcimm = PCIMM_C; pc4 = PC4_C;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;

    //                nm          ld we bc      addr          wd            ps    rfwe wa     req mis be       e_addr        e_wdata       e_fwd         wbwe e_wbwd
    vt[0]  = '{"sw_w",     1'b0,1'b1,3'b010,32'h00000100,32'hDEADBEEF,2'b00,1'b0,5'd0, 1'b1,1'b0,4'b1111,32'h00000100,32'hDEADBEEF,32'h00000100,1'b0,32'h0};
    vt[1]  = '{"sh_hi",    1'b0,1'b1,3'b001,32'h00000102,32'h1234CAFE,2'b00,1'b0,5'd0, 1'b1,1'b0,4'b1100,32'h00000100,32'hCAFECAFE,32'h00000102,1'b0,32'h0};
    vt[2]  = '{"sb_b1",    1'b0,1'b1,3'b000,32'h00000101,32'h00000055,2'b00,1'b0,5'd0, 1'b1,1'b0,4'b0010,32'h00000100,32'h55555555,32'h00000101,1'b0,32'h0};
    vt[3]  = '{"lh_mis",   1'b1,1'b0,3'b001,32'h00000101,32'h0,       2'b00,1'b1,5'd3, 1'b0,1'b1,4'b0000,32'h0,       32'h0,       32'h00000101,1'b0,32'h0};
    vt[4]  = '{"sw_mis",   1'b0,1'b1,3'b010,32'h00000102,32'h00000001,2'b00,1'b0,5'd0, 1'b0,1'b1,4'b0000,32'h0,       32'h0,       32'h00000102,1'b0,32'h0};
    vt[5]  = '{"lhu_mis",  1'b1,1'b0,3'b101,32'h00000103,32'h0,       2'b00,1'b1,5'd4, 1'b0,1'b1,4'b0000,32'h0,       32'h0,       32'h00000103,1'b0,32'h0};
    vt[6]  = '{"lw_mis",   1'b1,1'b0,3'b010,32'h00000201,32'h0,       2'b00,1'b1,5'd4, 1'b0,1'b1,4'b0000,32'h0,       32'h0,       32'h00000201,1'b0,32'h0};
    vt[7]  = '{"addi_pc4", 1'b0,1'b0,3'b000,32'h00000007,32'h0,       2'b11,1'b1,5'd5, 1'b0,1'b0,4'b0000,32'h0,       32'h0,       PC4_C,       1'b1,PC4_C};
    vt[8]  = '{"lui_imm",  1'b0,1'b0,3'b000,32'h00000008,32'h0,       2'b01,1'b1,5'd6, 1'b0,1'b0,4'b0000,32'h0,       32'h0,       IMM_C,       1'b1,IMM_C};
    vt[9]  = '{"auipc",    1'b0,1'b0,3'b000,32'h00000009,32'h0,       2'b10,1'b1,5'd7, 1'b0,1'b0,4'b0000,32'h0,       32'h0,       PCIMM_C,     1'b1,PCIMM_C};
    vt[10] = '{"alu_res",  1'b0,1'b0,3'b000,32'hFFFFFFF0,32'h0,       2'b00,1'b1,5'd8, 1'b0,1'b0,4'b0000,32'h0,       32'h0,       32'hFFFFFFF0,1'b1,32'hFFFFFFF0};

    // Reset with a granted store on the inputs: everything must stay quiet.
    rst = 1'b1;
    drive(1'b0, 1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 2'b00, 1'b1, 5'd1);
    gnt = 1'b1;
    tick(); tick();
    settle();
    chk("rst_req", req, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mis", mis, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_be", be, 4'b0000);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_wa", wb_wa, 5'd0);
    chk("rst_wb_wd", wb_wd, 32'h0);
    tick();
    rst = 1'b0;
    drive_idle();
    gnt = 1'b0;
    tick();

    // Single-cycle vectors: immediate grant, misaligned accesses, non-memory ops.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].ld, vt[i].we, vt[i].bc, vt[i].a, vt[i].wd, vt[i].ps, vt[i].rfwe, vt[i].wa);
      gnt = 1'b1;
      settle();
      chk({vt[i].nm, "_req"}, req, vt[i].e_req);
      chk({vt[i].nm, "_stall"}, stall, 1'b0);
      chk({vt[i].nm, "_mis"}, mis, vt[i].e_mis);
      chk({vt[i].nm, "_fwd"}, fwd, vt[i].e_fwd);
      if (vt[i].e_req) begin
        chk({vt[i].nm, "_wr"}, wr, vt[i].we);
        chk({vt[i].nm, "_be"}, be, vt[i].e_be);
        chk({vt[i].nm, "_addr"}, addr, vt[i].e_addr);
        chk({vt[i].nm, "_wdata"}, wdata, vt[i].e_wdata);
      end
      tick();
      chk({vt[i].nm, "_wb_we"}, wb_we, vt[i].e_wbwe);
      if (vt[i].e_wbwe) begin
        chk({vt[i].nm, "_wb_wa"}, wb_wa, vt[i].wa);
        chk({vt[i].nm, "_wb_wd"}, wb_wd, vt[i].e_wbwd);
      end
    end
    gnt = 1'b0;
    drive_idle();
    tick();

    // SB 0xAB @0x103 with grant two cycles late.
    drive(1'b0, 1'b1, 3'b000, 32'h00000103, 32'h000000AB, 2'b00, 1'b0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("sb_late_stall", stall, 1'b1);
      chk("sb_late_req", req, 1'b1);
      chk("sb_late_be", be, 4'b1000);
      chk("sb_late_wdata", wdata, 32'hABABABAB);
      tick();
    end
    gnt = 1'b1;
    settle();
    chk("sb_late_stall_gnt", stall, 1'b0);
    chk("sb_late_addr", addr, 32'h00000100);
    chk("sb_late_wr", wr, 1'b1);
    tick();
    gnt = 1'b0;
    drive_idle();

    // Sub-word loads with sign/zero extension.
    run_load("lb_sx",  3'b000, 32'h00000102, 32'h0080FF00, 0, 0, 32'hFFFFFF80);
    run_load("lbu_zx", 3'b100, 32'h00000102, 32'h0080FF00, 1, 2, 32'h00000080);
    run_load("lb_pos", 3'b000, 32'h00000101, 32'h00007F00, 0, 1, 32'h0000007F);
    run_load("lh_sx",  3'b001, 32'h00000102, 32'h80010000, 0, 0, 32'hFFFF8001);
    run_load("lhu_zx", 3'b101, 32'h00000102, 32'hBEEF1234, 0, 0, 32'h0000BEEF);

    // Misaligned LH followed directly by a normal LW.
    drive(1'b1, 1'b0, 3'b001, 32'h00000101, 32'h0, 2'b00, 1'b1, 5'd3);
    settle();
    chk("lh101_mis", mis, 1'b1);
    chk("lh101_req", req, 1'b0);
    chk("lh101_stall", stall, 1'b0);
    tick();
    chk("lh101_wb_we", wb_we, 1'b0);
    run_load("lw204", 3'b010, 32'h00000204, 32'h11223344, 0, 1, 32'h11223344);

    // Reset while waiting for read data; a late rvalid must be dropped.
    drive(1'b1, 1'b0, 3'b010, 32'h00000400, 32'h0, 2'b00, 1'b1, 5'd7);
    gnt = 1'b1;
    settle();
    chk("rstw_stall_gnt", stall, 1'b1);
    tick();
    gnt = 1'b0;
    settle();
    chk("rstw_stall_wait", stall, 1'b1);
    rst = 1'b1;
    drive_idle();
    settle();
    chk("rstw_stall_in_rst", stall, 1'b0);
    tick();
    rst = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hBAD0BAD0;
    drive(1'b0, 1'b0, 3'b000, 32'h00000055, 32'h0, 2'b00, 1'b0, 5'd2);
    settle();
    chk("rstw_late_rv_stall", stall, 1'b0);
    chk("rstw_late_rv_req", req, 1'b0);
    tick();
    rvalid = 1'b0;
    chk("rstw_wb_we", wb_we, 1'b0);
    chk("rstw_wb_wd", wb_wd, 32'h00000055);
    run_load("rstw_next_lw", 3'b010, 32'h00000404, 32'hA5A5A5A5, 1, 0, 32'hA5A5A5A5);

    // Back-to-back SW then LW to the same word.
    drive(1'b0, 1'b1, 3'b010, 32'h00000300, 32'hCAFEF00D, 2'b00, 1'b0, 5'd0);
    gnt = 1'b1;
    settle();
    chk("b2b_sw_req", req, 1'b1);
    chk("b2b_sw_wr", wr, 1'b1);
    chk("b2b_sw_stall", stall, 1'b0);
    chk("b2b_sw_wdata", wdata, 32'hCAFEF00D);
    tick();
    chk("b2b_sw_wb_we", wb_we, 1'b0);
    run_load("b2b_lw", 3'b010, 32'h00000300, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
